// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the divider request sequencer
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_RESP   = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 4;
  localparam int DIV_MAX_WIDTH     = 64;

  // Quotient reported for a zero divisor; sliced down to the instance width.
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_watchdog.sv
// rtl/div_watchdog.sv - BUSY-cycle counter that flags expiry after TIMEOUT enabled cycles
module div_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q, count_d;

  // Counts 0..TIMEOUT-1, so expiry lands on the TIMEOUT-th enabled cycle.
  assign expired = enable && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/div_request_sequencer.sv
// rtl/div_request_sequencer.sv - single-request sequencer between requester, divider and consumer
// Optional BUSY timeout abort enabled by defining DIV_TIMEOUT_EN.
module div_request_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             go,
  output logic             error,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  input  logic             done,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] rem_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quot,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_err
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             err_q, err_d;

`ifdef DIV_TIMEOUT_EN
  logic wd_expired;

  // Clearing during LAUNCH means the count starts at zero on BUSY entry.
  div_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == ST_LAUNCH),
    .enable  (state_q == ST_BUSY),
    .expired (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          x_d = req_x;
          y_d = req_y;
          if (req_y == '0) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            quot_d  = DIV_ZERO_QUOT[WIDTH-1:0];
            rem_d   = req_x;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY: begin
        // A real completion wins over a timeout landing on the same cycle.
        if (done) begin
          state_d = ST_RESP;
          quot_d  = quot_in;
          rem_d   = rem_in;
          err_d   = 1'b0;
`ifdef DIV_TIMEOUT_EN
        end else if (wd_expired) begin
          state_d = ST_RESP;
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // LAUNCH is only reachable with a nonzero divisor, so go and error never coincide.
  assign req_ready = (state_q == ST_IDLE);
  assign go        = (state_q == ST_LAUNCH);
  assign error     = (y_q == '0);
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_quot  = quot_q;
  assign rsp_rem   = rem_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// tb/tb_div_request_sequencer.sv - randomized self-checking bench with an arithmetic divider model
module tb_div_request_sequencer;

  localparam int W  = 4;
  localparam int TO = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_x, req_y;
  logic         go, error;
  logic [W-1:0] x_out, y_out;
  logic         done;
  logic [W-1:0] quot_in, rem_in;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_quot, rsp_rem;
  logic         rsp_err;

  int checks   = 0;
  int failures = 0;

  div_request_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .go        (go),
    .error     (error),
    .x_out     (x_out),
    .y_out     (y_out),
    .done      (done),
    .quot_in   (quot_in),
    .rem_in    (rem_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_quot  (rsp_quot),
    .rsp_rem   (rsp_rem),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  function automatic void model(input int x, input int y, output int q, output int r, output int e);
    if (y == 0) begin
      q = (1 << W) - 1;
      r = x;
      e = 1;
    end else begin
      q = x / y;
      r = x % y;
      e = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) check("go_error_excl", {31'd0, go & error}, 32'd0);
  end

  task automatic do_txn(input int x, input int y, input int lat, input int hold, input bit junk);
    int q, r, e;
    model(x, y, q, r, e);
    step;
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    req_x     = W'(x);
    req_y     = W'(y);
    step;
    req_valid = 1'b0;
    req_x     = W'($urandom);
    req_y     = W'($urandom);
    if (y == 0) begin
      check("dz_no_go", go, 0);
      check("dz_latency", rsp_valid, 1);
      check("dz_error", error, 1);
    end else begin
      check("launch_go", go, 1);
      check("launch_no_rsp", rsp_valid, 0);
      check("launch_not_ready", req_ready, 0);
      check("launch_x_out", x_out, x);
      check("launch_y_out", y_out, y);
      if (junk) begin
        done    = 1'b1;
        quot_in = W'($urandom);
        rem_in  = W'($urandom);
      end
      for (int i = 1; i <= lat; i++) begin
        step;
        check("go_once", go, 0);
        check("busy_no_rsp", rsp_valid, 0);
        check("busy_x_hold", x_out, x);
        check("busy_y_hold", y_out, y);
        if (i == lat) begin
          done    = 1'b1;
          quot_in = W'(q);
          rem_in  = W'(r);
        end else begin
          done    = 1'b0;
          quot_in = W'($urandom);
          rem_in  = W'($urandom);
        end
      end
      step;
      done    = 1'b0;
      quot_in = W'($urandom);
      rem_in  = W'($urandom);
      check("rsp_latency", rsp_valid, 1);
    end
    check("rsp_quot", rsp_quot, q);
    check("rsp_rem", rsp_rem, r);
    check("rsp_err", rsp_err, e);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (junk) begin
        req_valid = 1'b1;
        req_x     = W'($urandom);
        req_y     = W'($urandom);
        done      = 1'b1;
        quot_in   = W'($urandom);
        rem_in    = W'($urandom);
      end
      step;
      check("hold_valid", rsp_valid, 1);
      check("hold_quot", rsp_quot, q);
      check("hold_rem", rsp_rem, r);
      check("hold_err", rsp_err, e);
      check("hold_not_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    done      = 1'b0;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_ready", req_ready, 1);
    check("no_early_accept_x", x_out, x);
    check("no_early_accept_y", y_out, y);
  endtask

  task automatic reset_mid_busy;
    step;
    req_valid = 1'b1;
    req_x     = W'(11);
    req_y     = W'(3);
    step;
    req_valid = 1'b0;
    check("rm_go", go, 1);
    step;
    step;
    rst = 1'b1;
    step;
    rst     = 1'b0;
    done    = 1'b1;
    quot_in = W'(3);
    rem_in  = W'(2);
    step;
    done = 1'b0;
    check("rm_no_rsp", rsp_valid, 0);
    check("rm_ready", req_ready, 1);
    check("rm_x_cleared", x_out, 0);
    check("rm_quot_cleared", rsp_quot, 0);
    step;
    check("rm_still_no_rsp", rsp_valid, 0);
    do_txn(7, 2, 3, 0, 1'b0);
  endtask

`ifdef DIV_TIMEOUT_EN
  task automatic timeout_case;
    step;
    req_valid = 1'b1;
    req_x     = W'(5);
    req_y     = W'(2);
    step;
    req_valid = 1'b0;
    check("to_go", go, 1);
    for (int i = 1; i <= TO; i++) begin
      step;
      check("to_wait", rsp_valid, 0);
    end
    step;
    check("to_expire", rsp_valid, 1);
    check("to_err", rsp_err, 1);
    check("to_quot", rsp_quot, 0);
    check("to_rem", rsp_rem, 0);
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    check("to_post_hs", rsp_valid, 0);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    done      = 1'b0;
    quot_in   = '0;
    rem_in    = '0;
    rsp_ready = 1'b0;
    repeat (3) step;
    check("rst_go", go, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_quot", rsp_quot, 0);
    check("rst_rsp_rem", rsp_rem, 0);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    rst = 1'b0;
    step;
    check("rst_ready", req_ready, 1);

    do_txn(13, 4, 3, 0, 1'b0);
    do_txn(9, 0, 1, 0, 1'b0);
    do_txn(13, 4, 2, 10, 1'b1);
    do_txn(9, 0, 1, 10, 1'b1);
    reset_mid_busy();
`ifdef DIV_TIMEOUT_EN
    timeout_case();
`else
    do_txn(11, 3, 50, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      int x, y;
      x = int'($urandom_range(0, 15));
      y = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
      do_txn(x, y, int'($urandom_range(1, 5)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
